// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter
// Shares one i2c_dri engine between NUM_REQ requesters. Each accepted request
// becomes exactly one i2c_exec / i2c_done transaction. The result (read data,
// timeout flag) is returned to the owner with a one-cycle req_done pulse.
//
// Optional build macro: I2C_ARB_FIXED_PRIO_EN
//   defined   : requester 0 wins whenever its req_vld is high; requesters
//               1..NUM_REQ-1 rotate among themselves, and requester-0 grants
//               leave the rotation pointer untouched.
//   undefined : plain round-robin across all requesters.

module i2c_req_arbiter #(
    parameter int          NUM_REQ     = 3,
    parameter logic [19:0] TIMEOUT_CYC = 20'd100_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_vld,
    input  logic [NUM_REQ-1:0]    req_rh_wl,
    input  logic [NUM_REQ-1:0]    req_bit_ctrl,
    input  logic [NUM_REQ*16-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]    req_done,
    output logic                  req_err,
    output logic [7:0]            req_rdata,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  busy,
    output logic                  i2c_exec,
    output logic                  i2c_rh_wl,
    output logic                  i2c_bit_ctrl,
    output logic [15:0]           i2c_addr,
    output logic [7:0]            i2c_data_w,
    input  logic [7:0]            i2c_data_r,
    input  logic                  i2c_done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Extra bit so that pointer + offset never overflows before wrap-around.
    localparam logic [IDX_W:0]   NUM_REQ_EXT = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);

    logic [1:0]         state_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [IDX_W-1:0]   owner_reg;
    logic [NUM_REQ-1:0] grant_reg;
    logic [19:0]        cnt_reg;
    logic [7:0]         rdata_reg;
    logic               err_reg;
    logic               rh_wl_reg;
    logic               bit_ctrl_reg;
    logic [15:0]        addr_reg;
    logic [7:0]         wdata_reg;

    // Unpacked per-requester views of the packed command buses.
    logic [15:0] addr_arr  [NUM_REQ];
    logic [7:0]  wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[16*gi +: 16];
            assign wdata_arr[gi] = req_wdata[8*gi +: 8];
        end
    endgenerate

    logic [NUM_REQ-1:0] rr_req;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W:0]     cand;

    // Winner selection: first pending requester after rr_ptr, wrapping round.
    always_comb begin
        rr_req    = req_vld;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
`ifdef I2C_ARB_FIXED_PRIO_EN
        // Requester 0 is handled by the priority override below.
        rr_req[0] = 1'b0;
`endif
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = {1'b0, rr_ptr_reg} + (IDX_W+1)'(off);
            if (cand >= NUM_REQ_EXT) begin
                cand = cand - NUM_REQ_EXT;
            end
            if (!win_found && rr_req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
`ifdef I2C_ARB_FIXED_PRIO_EN
        if (req_vld[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end
`endif
    end

    // Counter value after this WAIT cycle; abort once it reaches TIMEOUT_CYC-1.
    logic [19:0] cnt_inc;
    logic        timeout_hit;

    assign cnt_inc     = cnt_reg + 20'd1;
    assign timeout_hit = (cnt_inc == (TIMEOUT_CYC - 20'd1));

    // Transaction sequencer: grant, issue, wait for completion or timeout, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= LAST_IDX;
            owner_reg    <= '0;
            grant_reg    <= '0;
            cnt_reg      <= '0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
            rh_wl_reg    <= 1'b0;
            bit_ctrl_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (win_found) begin
                        grant_reg    <= NUM_REQ'(1) << win_idx;
                        owner_reg    <= win_idx;
                        rh_wl_reg    <= req_rh_wl[win_idx];
                        bit_ctrl_reg <= req_bit_ctrl[win_idx];
                        addr_reg     <= addr_arr[win_idx];
                        wdata_reg    <= wdata_arr[win_idx];
                        state_reg    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_reg   <= '0;
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_inc;
                    // A completion in the same cycle as the timeout takes precedence.
                    if (i2c_done) begin
                        rdata_reg <= i2c_data_r;
                        err_reg   <= 1'b0;
                        state_reg <= ST_RESP;
                    end else if (timeout_hit) begin
                        rdata_reg <= '0;
                        err_reg   <= 1'b1;
                        state_reg <= ST_RESP;
                    end
                end
                default: begin
`ifdef I2C_ARB_FIXED_PRIO_EN
                    if (owner_reg != '0) begin
                        rr_ptr_reg <= owner_reg;
                    end
`else
                    rr_ptr_reg <= owner_reg;
`endif
                    grant_reg <= '0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign i2c_exec     = (state_reg == ST_ISSUE);
    assign busy         = (state_reg != ST_IDLE);
    assign grant        = grant_reg;
    assign req_done     = (state_reg == ST_RESP) ? grant_reg : '0;
    assign req_err      = err_reg;
    assign req_rdata    = rdata_reg;
    assign i2c_rh_wl    = rh_wl_reg;
    assign i2c_bit_ctrl = bit_ctrl_reg;
    assign i2c_addr     = addr_reg;
    assign i2c_data_w   = wdata_reg;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter (NUM_REQ = 3, TIMEOUT_CYC = 50).
// The bench plays both the requesters and the i2c_dri engine; expected grants
// come from a modular-arithmetic round-robin model of the arbitration rules.

module tb_i2c_req_arbiter;

    localparam int          N  = 3;
    localparam logic [19:0] TO = 20'd50;
    localparam int          TO_I = 50;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_vld;
    logic [N-1:0]    req_rh_wl;
    logic [N-1:0]    req_bit_ctrl;
    logic [N*16-1:0] req_addr;
    logic [N*8-1:0]  req_wdata;
    logic [N-1:0]    req_done;
    logic            req_err;
    logic [7:0]      req_rdata;
    logic [N-1:0]    grant;
    logic            busy;
    logic            i2c_exec;
    logic            i2c_rh_wl;
    logic            i2c_bit_ctrl;
    logic [15:0]     i2c_addr;
    logic [7:0]      i2c_data_w;
    logic [7:0]      i2c_data_r;
    logic            i2c_done;

    int checks = 0;
    int errors = 0;
    int model_ptr;

    i2c_req_arbiter #(
        .NUM_REQ     (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_vld      (req_vld),
        .req_rh_wl    (req_rh_wl),
        .req_bit_ctrl (req_bit_ctrl),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_done     (req_done),
        .req_err      (req_err),
        .req_rdata    (req_rdata),
        .grant        (grant),
        .busy         (busy),
        .i2c_exec     (i2c_exec),
        .i2c_rh_wl    (i2c_rh_wl),
        .i2c_bit_ctrl (i2c_bit_ctrl),
        .i2c_addr     (i2c_addr),
        .i2c_data_w   (i2c_data_w),
        .i2c_data_r   (i2c_data_r),
        .i2c_done     (i2c_done)
    );

    always #5 clk = ~clk;

    // Reference arbitration: next pending requester after the last owner.
    function automatic int model_pick(input logic [N-1:0] p);
`ifdef I2C_ARB_FIXED_PRIO_EN
        if (p[0]) return 0;
        for (int off = 1; off <= N; off++) begin
            int c;
            c = (model_ptr + off) % N;
            if (c != 0 && p[c]) return c;
        end
`else
        for (int off = 1; off <= N; off++) begin
            int c;
            c = (model_ptr + off) % N;
            if (p[c]) return c;
        end
`endif
        return -1;
    endfunction

    function automatic void model_update(input int w);
`ifdef I2C_ARB_FIXED_PRIO_EN
        if (w != 0) model_ptr = w;
`else
        model_ptr = w;
`endif
    endfunction

    task automatic set_cmd(input int i, input logic rh, input logic bc,
                           input logic [15:0] a, input logic [7:0] w);
        req_rh_wl[i]        = rh;
        req_bit_ctrl[i]     = bc;
        req_addr[16*i +: 16] = a;
        req_wdata[8*i +: 8]  = w;
    endtask

    // Acts as i2c_dri for one transaction and records what the arbiter did.
    // d = cycles from exec to i2c_done (0 = never answer). The owner drops
    // req_vld on seeing req_done unless keep is set. Returns at the negedge
    // of the cycle after req_done.
    task automatic do_txn(input int d, input logic [7:0] rd, input bit keep, input bit scramble,
                          output bit exec_ok, output bit done_ok,
                          output logic [N-1:0] g, output logic [15:0] a, output logic [7:0] w,
                          output logic rh, output logic bc, output int lat,
                          output logic [N-1:0] dn, output logic er, output logic [7:0] rdo,
                          output int extra_exec, output bit busy_all, output logic [15:0] a_end);
        exec_ok = 0; done_ok = 0; g = '0; a = '0; w = '0; rh = 0; bc = 0; lat = 0;
        dn = '0; er = 0; rdo = '0; extra_exec = 0; busy_all = 1; a_end = '0;
        for (int c = 0; c < 20 && !exec_ok; c++) begin
            @(negedge clk);
            if (i2c_exec) begin
                exec_ok = 1; g = grant; a = i2c_addr; w = i2c_data_w;
                rh = i2c_rh_wl; bc = i2c_bit_ctrl;
                if (!busy) busy_all = 0;
            end
        end
        if (!exec_ok) return;
        if (scramble) begin
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    req_addr[16*i +: 16] = 16'($urandom);
                    req_wdata[8*i +: 8]  = 8'($urandom);
                end
            end
        end
        for (int t = 1; t <= TO_I + 20 && !done_ok; t++) begin
            @(negedge clk);
            if (!busy) busy_all = 0;
            if (i2c_exec) extra_exec++;
            if (req_done != '0) begin
                done_ok = 1; lat = t; dn = req_done; er = req_err; rdo = req_rdata;
                a_end = i2c_addr;
                if (!keep) req_vld = req_vld & ~req_done;
            end
            i2c_done   = (t == d);
            i2c_data_r = (t == d) ? rd : ~rd;
        end
        @(negedge clk);
        i2c_done = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_vld = '0; req_rh_wl = '0; req_bit_ctrl = '0;
        req_addr = '0; req_wdata = '0; i2c_done = 1'b0; i2c_data_r = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({grant, busy, i2c_exec, req_done} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: grant=%b busy=%b exec=%b done=%b, expected all 0", grant, busy, i2c_exec, req_done);
        end
        checks++;
        if ({req_err, req_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_resp: err=%b rdata=%h, expected 0/00", req_err, req_rdata);
        end
        checks++;
        if ({i2c_rh_wl, i2c_bit_ctrl, i2c_addr, i2c_data_w} !== '0) begin
            errors++;
            $display("FAIL reset_i2c: rh=%b bc=%b addr=%h data=%h, expected 0", i2c_rh_wl, i2c_bit_ctrl, i2c_addr, i2c_data_w);
        end
        rst_n = 1'b1;
        model_ptr = N - 1;
        @(negedge clk);
        $display("reset: outputs checked");
    endtask

    task automatic test_single_write;
        bit eo, dok, ba; logic [N-1:0] g, dn; logic [15:0] a, ae; logic [7:0] w, rdo;
        logic rh, bc, er; int lat, xe, exp;
        set_cmd(1, 1'b0, 1'b0, 16'h0012, 8'h80);
        req_vld = 3'b010;
        exp = model_pick(req_vld);
        do_txn(40, 8'h5A, 0, 0, eo, dok, g, a, w, rh, bc, lat, dn, er, rdo, xe, ba, ae);
        model_update(exp);
        checks++;
        if (!(eo && dok) || g !== 3'(1 << exp) || a !== 16'h0012 || w !== 8'h80 || rh !== 1'b0) begin
            errors++;
            $display("FAIL write_issue: exec=%0d done=%0d grant=%b addr=%h data=%h rh=%b, expected 1 1 %b 0012 80 0", eo, dok, g, a, w, rh, 3'(1 << exp));
        end
        checks++;
        if (lat != 41 || dn !== 3'b010 || er !== 1'b0 || xe != 0 || !ba) begin
            errors++;
            $display("FAIL write_resp: lat=%0d done=%b err=%b extra_exec=%0d busy_ok=%0d, expected 41 010 0 0 1", lat, dn, er, xe, ba);
        end
        checks++;
        if (busy !== 1'b0 || grant !== '0) begin
            errors++;
            $display("FAIL write_idle: busy=%b grant=%b, expected 0 000", busy, grant);
        end
        $display("single_write: grant=%b addr=%h lat=%0d err=%b", g, a, lat, er);
    endtask

    task automatic test_read;
        bit eo, dok, ba; logic [N-1:0] g, dn; logic [15:0] a, ae; logic [7:0] w, rdo;
        logic rh, bc, er; int lat, xe, d, exp;
        set_cmd(2, 1'b1, 1'b1, 16'h000A, 8'h00);
        req_vld = 3'b100;
        exp = model_pick(req_vld);
        d = $urandom_range(1, 30);
        do_txn(d, 8'h77, 0, 0, eo, dok, g, a, w, rh, bc, lat, dn, er, rdo, xe, ba, ae);
        model_update(exp);
        checks++;
        if (!(eo && dok) || rdo !== 8'h77 || dn !== 3'b100 || er !== 1'b0 || lat != d + 1) begin
            errors++;
            $display("FAIL read_resp: exec=%0d done=%0d rdata=%h done=%b err=%b lat=%0d, expected 77 100 0 %0d", eo, dok, rdo, dn, er, lat, d + 1);
        end
        checks++;
        if (rh !== 1'b1 || bc !== 1'b1 || a !== 16'h000A) begin
            errors++;
            $display("FAIL read_issue: rh=%b bc=%b addr=%h, expected 1 1 000a", rh, bc, a);
        end
        $display("read: rdata=%h lat=%0d", rdo, lat);
    endtask

    task automatic test_contention;
        bit eo, dok, ba; logic [N-1:0] g, dn; logic [15:0] a, ae; logic [7:0] w, rdo;
        logic rh, bc, er; int lat, xe, exp;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = N - 1;
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 1'b0, 16'h0100 + 16'(i), 8'h10 + 8'(i));
        req_vld = 3'b111;
        for (int n = 0; n < 4; n++) begin
            exp = model_pick(req_vld);
            do_txn($urandom_range(1, 20), 8'($urandom), 1, 0, eo, dok, g, a, w, rh, bc, lat, dn, er, rdo, xe, ba, ae);
            model_update(exp);
            checks++;
            if (!(eo && dok) || g !== 3'(1 << exp) || dn !== g || a !== 16'h0100 + 16'(exp) || xe != 0) begin
                errors++;
                $display("FAIL contention_%0d: grant=%b done=%b addr=%h extra_exec=%0d, expected grant %b addr %h", n, g, dn, a, xe, 3'(1 << exp), 16'h0100 + 16'(exp));
            end
            $display("contention %0d: grant=%b addr=%h", n, g, a);
        end
        req_vld = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout;
        bit eo, dok, ba, bad; logic [N-1:0] g, dn; logic [15:0] a, ae; logic [7:0] w, rdo;
        logic rh, bc, er; int lat, xe, exp;
        // Never answers.
        set_cmd(0, 1'b1, 1'b0, 16'h0033, 8'h00);
        req_vld = 3'b001;
        exp = model_pick(req_vld);
        do_txn(0, 8'h99, 0, 0, eo, dok, g, a, w, rh, bc, lat, dn, er, rdo, xe, ba, ae);
        model_update(exp);
        checks++;
        if (!(eo && dok) || lat != TO_I || dn !== 3'b001 || er !== 1'b1 || rdo !== 8'h00) begin
            errors++;
            $display("FAIL timeout: done=%0d lat=%0d done=%b err=%b rdata=%h, expected 50 001 1 00", dok, lat, dn, er, rdo);
        end
        $display("timeout: lat=%0d err=%b", lat, er);
        // Late completion while idle must be ignored.
        i2c_done = 1'b1; i2c_data_r = 8'hEE;
        @(negedge clk);
        i2c_done = 1'b0;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (req_done !== '0 || busy !== 1'b0) bad = 1;
            @(negedge clk);
        end
        checks++;
        if (bad || req_err !== 1'b1 || req_rdata !== 8'h00) begin
            errors++;
            $display("FAIL late_done: spurious activity or held response changed err=%b rdata=%h, expected 1 00", req_err, req_rdata);
        end
        $display("late_done: ignored check done");
    endtask

    task automatic test_boundary;
        bit eo, dok, ba; logic [N-1:0] g, dn; logic [15:0] a, ae; logic [7:0] w, rdo;
        logic rh, bc, er; int lat, xe, exp;
        // Completion in the same cycle the timeout would fire: completion wins.
        set_cmd(1, 1'b1, 1'b0, 16'h0044, 8'h00);
        req_vld = 3'b010;
        exp = model_pick(req_vld);
        do_txn(TO_I - 1, 8'h3C, 0, 0, eo, dok, g, a, w, rh, bc, lat, dn, er, rdo, xe, ba, ae);
        model_update(exp);
        checks++;
        if (!(eo && dok) || lat != TO_I || er !== 1'b0 || rdo !== 8'h3C || dn !== 3'b010) begin
            errors++;
            $display("FAIL done_at_timeout: lat=%0d err=%b rdata=%h done=%b, expected 50 0 3c 010", lat, er, rdo, dn);
        end
        // One cycle later the timeout has already fired; the done lands in RESP.
        req_vld = 3'b010;
        exp = model_pick(req_vld);
        do_txn(TO_I, 8'hC3, 0, 0, eo, dok, g, a, w, rh, bc, lat, dn, er, rdo, xe, ba, ae);
        model_update(exp);
        checks++;
        if (!(eo && dok) || lat != TO_I || er !== 1'b1 || rdo !== 8'h00) begin
            errors++;
            $display("FAIL done_after_timeout: lat=%0d err=%b rdata=%h, expected 50 1 00", lat, er, rdo);
        end
        checks++;
        if (req_done !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_in_resp: done=%b busy=%b, expected 000 0", req_done, busy);
        end
        $display("boundary: timeout-edge transactions checked");
    endtask

    task automatic test_reset_mid_wait;
        bit eo, dok, ba, seen, bad; logic [N-1:0] g, dn; logic [15:0] a, ae; logic [7:0] w, rdo;
        logic rh, bc, er; int lat, xe, exp;
        set_cmd(2, 1'b0, 1'b1, 16'h1234, 8'h56);
        req_vld = 3'b100;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (i2c_exec) seen = 1;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (!seen || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_wait: exec_seen=%0d busy=%b, expected 1 1", seen, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, busy, i2c_exec, req_done, req_err, req_rdata, i2c_addr, i2c_data_w, i2c_rh_wl, i2c_bit_ctrl} !== '0) begin
            errors++;
            $display("FAIL async_reset: grant=%b busy=%b addr=%h data=%h, expected all 0", grant, busy, i2c_addr, i2c_data_w);
        end
        req_vld = '0;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (req_done !== '0) bad = 1;
        end
        rst_n = 1'b1;
        model_ptr = N - 1;
        @(negedge clk);
        checks++;
        if (bad || req_done !== '0) begin
            errors++;
            $display("FAIL reset_no_done: req_done pulsed during or after reset");
        end
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 1'b0, 16'h0200 + 16'(i), 8'h20 + 8'(i));
        req_vld = 3'b111;
        exp = model_pick(req_vld);
        do_txn(5, 8'h00, 0, 0, eo, dok, g, a, w, rh, bc, lat, dn, er, rdo, xe, ba, ae);
        model_update(exp);
        req_vld = '0;
        checks++;
        if (!(eo && dok) || g !== 3'b001 || exp != 0) begin
            errors++;
            $display("FAIL post_reset_grant: grant=%b, expected 001", g);
        end
        @(negedge clk);
        $display("reset_mid_wait: post-reset grant=%b", g);
    endtask

    task automatic test_random;
        bit eo, dok, ba; logic [N-1:0] g, dn; logic [15:0] a, ae; logic [7:0] w, rdo;
        logic rh, bc, er; int lat, xe, exp, d; logic [7:0] rd;
        logic [15:0] ea; logic [7:0] ew; logic erh, ebc; bit eto;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_vld[i] && $urandom_range(0, 1) == 1) begin
                    set_cmd(i, 1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom));
                    req_vld[i] = 1'b1;
                end
            end
            if (req_vld == '0) begin
                int i;
                i = $urandom_range(0, N - 1);
                set_cmd(i, 1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom));
                req_vld[i] = 1'b1;
            end
            exp = model_pick(req_vld);
            ea = req_addr[16*exp +: 16]; ew = req_wdata[8*exp +: 8];
            erh = req_rh_wl[exp]; ebc = req_bit_ctrl[exp];
            d = $urandom_range(1, 60);
            rd = 8'($urandom);
            eto = (d >= TO_I);
            do_txn(d, rd, 0, 1, eo, dok, g, a, w, rh, bc, lat, dn, er, rdo, xe, ba, ae);
            model_update(exp);
            checks++;
            if (!(eo && dok) || g !== 3'(1 << exp) || a !== ea || w !== ew || rh !== erh || bc !== ebc || ae !== ea) begin
                errors++;
                $display("FAIL rand_issue_%0d: grant=%b addr=%h data=%h rh=%b bc=%b addr_end=%h, expected %b %h %h %b %b", n, g, a, w, rh, bc, ae, 3'(1 << exp), ea, ew, erh, ebc);
            end
            checks++;
            if (dn !== 3'(1 << exp) || er !== eto || rdo !== (eto ? 8'h00 : rd) || lat != (eto ? TO_I : d + 1) || xe != 0 || !ba) begin
                errors++;
                $display("FAIL rand_resp_%0d: done=%b err=%b rdata=%h lat=%0d extra=%0d, expected %b %b %h %0d 0", n, dn, er, rdo, lat, xe, 3'(1 << exp), eto, eto ? 8'h00 : rd, eto ? TO_I : d + 1);
            end
            $display("random %0d: grant=%b d=%0d err=%b rdata=%h", n, g, d, er, rdo);
        end
        req_vld = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_contention();
        test_timeout();
        test_boundary();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
